// File: rtl/intro_scene_draw_pkg.sv
// rtl/intro_scene_draw_pkg.sv - shared geometry, colours and snapshot type for the intro scene
package graphicsPkg;

  localparam int SPRITE_LOG2 = 6;
  localparam int SPRITE_SIZE = 1 << SPRITE_LOG2;
  localparam int TIMING_W    = 26;

  localparam logic [11:0] TRANSPARENT    = 12'h0F0;
  localparam logic [11:0] LADDER_X       = 12'd500;
  localparam logic [11:0] LADDER_W       = 12'd32;
  localparam logic [11:0] LADDER_Y_BOT   = 12'd608;
  localparam logic [11:0] BG_COLOR       = 12'h000;
  localparam logic [11:0] PLATFORM_Y0    = 12'd207;
  localparam logic [11:0] PLATFORM_PITCH = 12'd96;
  localparam logic [11:0] PLATFORM_H     = 12'd8;
  localparam logic [11:0] HIT_COLOR      = 12'hF80;

  typedef struct packed {
    logic [11:0] xs;
    logic [11:0] ys;
    logic [3:0]  cs;
    logic [3:0]  ks;
    logic        as;
  } intro_snap_t;

  localparam intro_snap_t SNAP_RESET = '{xs: 12'd484, ys: 12'd672, cs: 4'd0, ks: 4'd0, as: 1'b1};

  typedef enum logic {ST_RUN, ST_DONE} intro_state_t;

  // True when line v lies inside any platform row whose mask bit is set.
  function automatic logic on_hit_platform(input logic [11:0] v, input logic [3:0] mask);
    logic        hit;
    logic [11:0] top;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      top = PLATFORM_Y0 + PLATFORM_PITCH * 12'(i);
      if (mask[i] && (v >= top) && (v < top + PLATFORM_H)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/intro_scene_draw_delay.sv
// rtl/intro_scene_draw_delay.sv - fixed-depth register delay line with synchronous clear
module delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/intro_scene_draw.sv
// rtl/intro_scene_draw.sv - composes the intro sprite, ladder erase and platform tint onto the pixel stream
module intro_scene_draw
  import graphicsPkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              vcount_in,
  input  logic [10:0]              hcount_in,
  input  logic                     vsync_in,
  input  logic                     hsync_in,
  input  logic                     vblnk_in,
  input  logic                     hblnk_in,
  input  logic [11:0]              rgb_in,
  input  logic                     animation,
  input  logic [11:0]              xpos,
  input  logic [11:0]              ypos,
  input  logic [3:0]               counter,
  input  logic [3:0]               ctl,
  output logic [2*SPRITE_LOG2-1:0] rom_addr,
  input  logic [11:0]              rom_data,
  output logic [10:0]              vcount_out,
  output logic [10:0]              hcount_out,
  output logic                     vsync_out,
  output logic                     hsync_out,
  output logic                     vblnk_out,
  output logic                     hblnk_out,
  output logic [11:0]              rgb_out,
  output logic                     intro_done
);

  intro_snap_t  snap;
  intro_state_t state, state_next;
  logic         vblnk_prev, snap_load, done_pulse;

  assign snap_load = vblnk_in && !vblnk_prev;

  // Snapshot once per frame so the sprite never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= SNAP_RESET;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (snap_load) begin
        snap <= '{xs: xpos, ys: ypos, cs: counter, ks: ctl,
                  as: animation && (state == ST_RUN)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      intro_done <= 1'b0;
    end else begin
      state      <= state_next;
      intro_done <= done_pulse;
    end
  end

  always_comb begin
    state_next = state;
    done_pulse = 1'b0;
    case (state)
      ST_RUN: begin
        if (snap_load && !animation) begin
          done_pulse = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_DONE;
    endcase
  end

  // Stage A: geometry decisions for the current pixel.
  logic [12:0]              h13, v13, xs13, ys13;
  logic [11:0]              h12, v12, seg;
  logic [SPRITE_LOG2-1:0]   dx, dy;
  logic                     hit_d, erase_d, plat_d;
  logic [2*SPRITE_LOG2-1:0] rom_addr_d;

  always_comb begin
    h13  = {2'b00, hcount_in};
    v13  = {2'b00, vcount_in};
    xs13 = {1'b0, snap.xs};
    ys13 = {1'b0, snap.ys};
    h12  = {1'b0, hcount_in};
    v12  = {1'b0, vcount_in};
    dx   = hcount_in[SPRITE_LOG2-1:0] - snap.xs[SPRITE_LOG2-1:0];
    dy   = vcount_in[SPRITE_LOG2-1:0] - snap.ys[SPRITE_LOG2-1:0];
    seg  = '0;

    // 13-bit sums so a sprite near the far edge clips instead of wrapping.
    hit_d = snap.as && (h13 >= xs13) && (h13 < xs13 + 13'(SPRITE_SIZE))
                    && (v13 >= ys13) && (v13 < ys13 + 13'(SPRITE_SIZE));
    rom_addr_d = hit_d ? {dy, dx} : '0;

    erase_d = 1'b0;
    if ((h12 >= LADDER_X) && (h12 < LADDER_X + LADDER_W) && (v12 < LADDER_Y_BOT)) begin
      seg     = (LADDER_Y_BOT - 12'd1 - v12) >> 5;
      erase_d = seg < {8'd0, snap.cs};
    end

    plat_d = on_hit_platform(v12, snap.ks);
  end

  logic hit_a, erase_a, plat_a, blank_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_a    <= 1'b0;
      erase_a  <= 1'b0;
      plat_a   <= 1'b0;
      blank_a  <= 1'b0;
      rom_addr <= '0;
    end else begin
      hit_a    <= hit_d;
      erase_a  <= erase_d;
      plat_a   <= plat_d;
      blank_a  <= vblnk_in || hblnk_in;
      rom_addr <= rom_addr_d;
    end
  end

  // Stage B: resolve which source overrides the delayed upstream pixel.
  logic        ovr_en;
  logic [11:0] ovr_color, rgb_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_en    <= 1'b0;
      ovr_color <= '0;
    end else begin
      ovr_en    <= 1'b1;
      ovr_color <= '0;
      if (blank_a) begin
        ovr_color <= 12'h000;
      end else if (hit_a && (rom_data != TRANSPARENT)) begin
        ovr_color <= rom_data;
      end else if (erase_a) begin
        ovr_color <= BG_COLOR;
      end else if (plat_a) begin
        ovr_color <= HIT_COLOR;
      end else begin
        ovr_en <= 1'b0;
      end
    end
  end

  delay #(.WIDTH(12), .DEPTH(2)) u_rgb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (rgb_in),
    .dout (rgb_d2)
  );

  assign rgb_out = ovr_en ? ovr_color : rgb_d2;

  logic [TIMING_W-1:0] timing_in, timing_out;

  assign timing_in = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};

  delay #(.WIDTH(TIMING_W), .DEPTH(2)) u_timing_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (timing_in),
    .dout (timing_out)
  );

  assign {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out} = timing_out;

endmodule

// File: tb/tb_intro_scene_draw.sv
// tb/tb_intro_scene_draw.sv - randomized self-checking bench for intro_scene_draw
module tb_intro_scene_draw;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0] rgb_in;
  logic        animation;
  logic [11:0] xpos, ypos;
  logic [3:0]  counter, ctl;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
  logic        intro_done;

  logic [11:0] rom [0:4095];
  assign rom_data = rom[rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  int   m_xs, m_ys, m_cs;
  logic [3:0] m_ks;
  bit   m_as, m_done;

  always #5 clk = ~clk;

  intro_scene_draw dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .animation(animation), .xpos(xpos), .ypos(ypos),
    .counter(counter), .ctl(ctl), .rom_addr(rom_addr), .rom_data(rom_data),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .intro_done(intro_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_xs = 484; m_ys = 672; m_cs = 0; m_ks = 4'd0; m_as = 1'b1; m_done = 1'b0;
  endtask

  // Expected composed pixel from the scene rules, using the current model snapshot.
  function automatic logic [11:0] model_px(int h, int v, logic [11:0] rgb, bit blank);
    logic [11:0] w;
    if (blank) return 12'h000;
    if (m_as && h >= m_xs && h < m_xs + 64 && v >= m_ys && v < m_ys + 64) begin
      w = rom[(v - m_ys) * 64 + (h - m_xs)];
      if (w != 12'h0F0) return w;
    end
    if (h >= 500 && h < 532 && v < 608 && (607 - v) / 32 < m_cs) return 12'h000;
    for (int i = 0; i < 4; i++)
      if (m_ks[i] && v >= 207 + 96 * i && v < 215 + 96 * i) return 12'hF80;
    return rgb;
  endfunction

  task automatic drive_px(int h, int v, logic [11:0] rgb, bit hbl);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = rgb;
    hblnk_in  = hbl;
    hsync_in  = hbl;
    vsync_in  = 1'b0;
  endtask

  task automatic check_px(string name, int h, int v, bit hbl);
    logic [11:0] rgb, exp;
    rgb = 12'($urandom);
    drive_px(h, v, rgb, hbl);
    step();
    step();
    exp = model_px(h, v, rgb, hbl);
    n_checks++;
    if (rgb_out !== exp)
      $display("FAIL %s (%0d,%0d): rgb_out=%h expected %h", name, h, v, rgb_out, exp);
    else n_pass++;
  endtask

  // One vblank rising edge; the model loads its snapshot from the driven inputs.
  task automatic do_vblank();
    bit exp_pulse;
    drive_px(0, 0, 12'h000, 1'b0);
    vblnk_in = 1'b1;
    step();
    exp_pulse = !m_done && !animation;
    if (exp_pulse) m_done = 1'b1;
    m_xs = int'(xpos); m_ys = int'(ypos); m_cs = int'(counter); m_ks = ctl;
    m_as = animation && !m_done;
    n_checks++;
    if (intro_done !== exp_pulse)
      $display("FAIL vblank_pulse: intro_done=%b expected %b", intro_done, exp_pulse);
    else n_pass++;
    step();
    n_checks++;
    if (intro_done !== 1'b0)
      $display("FAIL vblank_pulse_width: intro_done=%b expected 0", intro_done);
    else n_pass++;
    vblnk_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_px(500, 700, 12'hABC, 1'b0);
    vsync_in = 1'b1;
    vblnk_in = 1'b0;
    animation = 1'b1; xpos = 12'd484; ypos = 12'd672; counter = 4'd0; ctl = 4'd0;
    repeat (3) step();
    n_checks++;
    if ({rgb_out, rom_addr, hcount_out, vcount_out, vsync_out, intro_done} !== '0)
      $display("FAIL reset_outputs: rgb=%h addr=%h h=%0d v=%0d vs=%b done=%b expected all 0",
               rgb_out, rom_addr, hcount_out, vcount_out, vsync_out, intro_done);
    else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_load();
    rom[28 * 64 + 16] = 12'h5A3;
    do_vblank();
    drive_px(500, 700, 12'h123, 1'b0);
    step();
    n_checks++;
    if (rom_addr !== 12'd1808) $display("FAIL rom_addr: got %0d expected 1808", rom_addr);
    else n_pass++;
    step();
    n_checks++;
    if (rgb_out !== 12'h5A3) $display("FAIL first_sprite_px: rgb_out=%h expected 5a3", rgb_out);
    else n_pass++;
    n_checks++;
    if (hcount_out !== 11'd500 || vcount_out !== 11'd700)
      $display("FAIL timing_delay: h=%0d v=%0d expected 500,700", hcount_out, vcount_out);
    else n_pass++;
  endtask

  task automatic test_midframe_move();
    xpos = 12'd100;
    check_px("old_pos_hit", 500, 700, 1'b0);
    check_px("new_pos_not_yet", 100, 700, 1'b0);
    do_vblank();
    check_px("new_pos_99", 99, 700, 1'b0);
    check_px("new_pos_100", 100, 700, 1'b0);
    check_px("new_pos_163", 163, 700, 1'b0);
    check_px("new_pos_164", 164, 700, 1'b0);
  endtask

  task automatic test_ladder();
    xpos = 12'd484; counter = 4'd3;
    do_vblank();
    check_px("ladder_607", 510, 607, 1'b0);
    check_px("ladder_560", 510, 560, 1'b0);
    check_px("ladder_512", 510, 512, 1'b0);
    check_px("ladder_511", 510, 511, 1'b0);
    check_px("ladder_col_532", 532, 600, 1'b0);
    counter = 4'd0;
    do_vblank();
    check_px("ladder_cnt0", 510, 607, 1'b0);
    counter = 4'd15;
    do_vblank();
    check_px("ladder_cap_128", 510, 128, 1'b0);
    check_px("ladder_cap_127", 510, 127, 1'b0);
  endtask

  task automatic test_platform();
    counter = 4'd0; ctl = 4'b0101;
    do_vblank();
    for (int i = 0; i < 8; i++) begin
      int lines [8] = '{206, 207, 214, 215, 303, 310, 399, 406};
      check_px("platform", 50, lines[i], 1'b0);
    end
  endtask

  task automatic test_transparent_blank();
    ctl = 4'd0;
    do_vblank();
    rom[28 * 64 + 16] = 12'h0F0;
    check_px("transparent", 500, 700, 1'b0);
    rom[28 * 64 + 16] = 12'h5A3;
    check_px("hblnk_on_sprite", 501, 700, 1'b1);
  endtask

  task automatic test_hold_during_vblank();
    bit seen;
    seen = 1'b0;
    animation = 1'b1;
    drive_px(0, 0, 12'h000, 1'b0);
    vblnk_in = 1'b1;
    step();
    m_xs = int'(xpos); m_ys = int'(ypos); m_cs = int'(counter); m_ks = ctl; m_as = 1'b1;
    animation = 1'b0;
    repeat (3) begin step(); seen |= intro_done; end
    vblnk_in = 1'b0;
    repeat (2) begin step(); seen |= intro_done; end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL hold_in_vblank: intro_done pulsed, expected none");
    else n_pass++;
    check_px("hold_sprite_visible", 500, 700, 1'b0);
    animation = 1'b1;
  endtask

  task automatic test_back_to_back();
    int hs [64];
    int vs [64];
    logic [11:0] rs [64];
    bit bs [64];
    logic [11:0] exp;
    for (int r = 0; r < 4; r++) begin
      xpos = 12'($urandom_range(0, 900)); ypos = 12'($urandom_range(0, 700));
      counter = 4'($urandom); ctl = 4'($urandom); animation = 1'b1;
      do_vblank();
      for (int k = 0; k < 64; k++) begin
        case ($urandom_range(0, 2))
          0: begin hs[k] = m_xs + $urandom_range(0, 79) - 8; vs[k] = m_ys + $urandom_range(0, 79) - 8; end
          1: begin hs[k] = $urandom_range(490, 540); vs[k] = $urandom_range(0, 640); end
          default: begin hs[k] = $urandom_range(0, 1023); vs[k] = $urandom_range(0, 767); end
        endcase
        if (hs[k] < 0) hs[k] = 0;
        if (vs[k] < 0) vs[k] = 0;
        rs[k] = 12'($urandom);
        bs[k] = ($urandom_range(0, 7) == 0);
        drive_px(hs[k], vs[k], rs[k], bs[k]);
        step();
        if (k >= 1) begin
          exp = model_px(hs[k-1], vs[k-1], rs[k-1], bs[k-1]);
          n_checks++;
          if (rgb_out !== exp || hcount_out !== 11'(hs[k-1]))
            $display("FAIL stream r%0d k%0d (%0d,%0d): rgb_out=%h h=%0d expected %h h=%0d",
                     r, k - 1, hs[k-1], vs[k-1], rgb_out, hcount_out, exp, hs[k-1]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_done();
    xpos = 12'd484; ypos = 12'd672; counter = 4'd0; ctl = 4'd0;
    animation = 1'b0;
    do_vblank();
    check_px("sprite_gone", 500, 700, 1'b0);
    animation = 1'b1;
    do_vblank();
    check_px("sprite_stays_gone", 500, 700, 1'b0);
    animation = 1'b0;
    do_vblank();
  endtask

  task automatic test_reset_midline();
    drive_px(500, 700, 12'h777, 1'b0);
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({rgb_out, rom_addr, hcount_out, vcount_out, hsync_out, intro_done} !== '0)
      $display("FAIL midline_reset: rgb=%h addr=%h h=%0d v=%0d expected all 0",
               rgb_out, rom_addr, hcount_out, vcount_out);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    xpos = 12'd300; animation = 1'b1;
    check_px("after_reset_snapshot", 500, 700, 1'b0);
    do_vblank();
    check_px("after_reset_reload", 300, 700, 1'b0);
    animation = 1'b0;
    do_vblank();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 12'($urandom);
      if (rom[i] == 12'h0F0) rom[i] = 12'h0F1;
    end
    model_reset();
    test_reset();
    test_first_load();
    test_midframe_move();
    test_ladder();
    test_platform();
    test_transparent_blank();
    test_hold_during_vblank();
    test_back_to_back();
    test_done();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intro_scene_draw.md
Name: intro_scene_draw

Overview:
- VGA pixel-pipeline stage that consumes the intro animation state (xpos, ypos, counter, ctl, animation) and renders it onto the incoming pixel stream.
- Sits between the background/map draw stage and the VGA output.
- Draws the Donkey sprite from an external synchronous ROM, erases climbed ladder segments, and tints platforms hit by landings.
- Samples animation state once per frame, at vblank start, for tear-free output; emits a one-shot intro_done when the animation ends.

Parameters:
SPRITE_LOG2, 6, sprite is 2^SPRITE_LOG2 pixels square (64x64)
TRANSPARENT, 12'h0F0, ROM colour treated as transparent
LADDER_X, 12'd500, left column of intro ladder
LADDER_W, 12'd32, ladder width in pixels
LADDER_Y_BOT, 12'd608, first line below ladder; segments are 32 lines each, counted upward
BG_COLOR, 12'h000, colour used to erase ladder segments
PLATFORM_Y0, 12'd207, top line of platform row 0
PLATFORM_PITCH, 12'd96, vertical spacing of platform rows
PLATFORM_H, 12'd8, platform thickness in lines
HIT_COLOR, 12'hF80, tint of platform rows whose ctl bit is set

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
vcount_in  in  11  vertical counter
hcount_in  in  11  horizontal counter
vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  timing
rgb_in  in  12  upstream pixel
animation  in  1  1 = intro running
xpos, ypos  in  12 each  sprite top-left
counter  in  4  ladder segments climbed
ctl  in  4  landed-jump mask
rom_addr  out  2*SPRITE_LOG2  sprite ROM address
rom_data  in  12  ROM pixel, valid 1 clk after rom_addr
vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out  out  as inputs  delayed timing
rgb_out  out  12  composed pixel
intro_done  out  1  single-cycle pulse

Behaviour:
- Snapshot registers xs, ys, cs, ks, as load xpos/ypos/counter/ctl/animation only on a vblnk_in rising edge (vblnk_in=1 and registered previous=0). All compositing uses the snapshots only.
- Snapshot reset values: xs=484, ys=672, cs=0, ks=0, as=1.
- Pipeline, latency exactly 2 clk on every output:
  - Stage A registers the timing signals, sprite hit, ladder-erase flag, platform flag and rom_addr.
  - The ROM returns data aligned with stage B.
  - Stage B registers rgb_out and the twice-delayed timing signals.
- Sprite hit: as=1 and hcount>=xs and hcount<xs+2^L and vcount>=ys and vcount<ys+2^L. Compute sums 13-bit with no wrap, so sprites near the right/bottom edge clip.
- rom_addr = {(vcount-ys)[L-1:0], (hcount-xs)[L-1:0]}. When there is no hit, rom_addr=0.
- Ladder erase: hcount in [LADDER_X, LADDER_X+LADDER_W) and vcount<LADDER_Y_BOT. Segment s=(LADDER_Y_BOT-1-vcount)>>5; erase when s<cs. cs=0 erases nothing; cs>=15 caps at 15 segments.
- Platform tint: line is within PLATFORM_H of PLATFORM_Y0+i*PLATFORM_PITCH, and ks[i]=1, for i in 0..3.
- Output priority, highest first:
  1. Blanking (vblnk or hblnk delayed) -> 12'h000.
  2. Sprite hit with rom_data != TRANSPARENT -> rom_data.
  3. Ladder erase -> BG_COLOR.
  4. Platform tint -> HIT_COLOR.
  5. Otherwise rgb_in delayed.
- intro_done FSM:
  - States: ST_RUN, ST_DONE.
  - Reset -> ST_RUN.
  - In ST_RUN, the snapshot load where animation=0 pulses intro_done=1 for exactly that clk and moves to ST_DONE.
  - ST_DONE holds until rst and never pulses again.
  - In ST_DONE the sprite is hidden (as=0); erase and tint continue.
- Reset mid-frame: all outputs 0 on the next clk, snapshots take reset values, FSM to ST_RUN. Output is valid again 2 clk after rst deasserts; the first new snapshot load occurs at the next vblank edge.
- animation changing while vblnk is already high has no effect until the next rising edge.

Decomposition:
- Shared package graphicsPkg holds: sprite size, TRANSPARENT, ladder and platform geometry constants, and the intro snapshot struct typedef (xs, ys, cs, ks, as).
- One natural sub-module, delay, is parameterised by width and depth. It is instantiated for the timing bus (depth 2) and for rgb_in (depth 2).

Test Plan:
- Reset, then xpos=484, ypos=672, animation=1, pixel (500,700): at the first vblank rising edge the snapshot loads; rgb_out equals the ROM word at addr {28,16} two clk after the pixel enters.
- Change xpos to 100 mid-frame: sprite position is unchanged until the next vblank rising edge, then hits at hcount 100..163 only.
- counter=3: pixels at x=510, y=607..512 show BG_COLOR; y=511 shows rgb_in; counter=0 shows no erase.
- ctl=4'b0101: lines 207..214 and 399..406 show HIT_COLOR; lines 303..310 pass rgb_in.
- rom_data=TRANSPARENT inside sprite -> rgb_in passes; hblnk asserted -> rgb_out=0 regardless of hit.
- animation falls, then a vblank edge -> intro_done high 1 clk and sprite gone; a second fall after toggling gives no pulse; rst mid-line zeroes outputs on the next clk.
